regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
// - Write-side controller for the 8x32 regfile: merges ALU and LSU results into its single write port.
// - Keeps a per-register pending-write scoreboard so decode can stall on RAW/WAW hazards.
// - Sits between the execute/LSU outputs and the regfile we/rd_addr/rd_data inputs.
// PARAMETERS
// - DATA_W    32  result / write-data width (must match regfile data width)
// - RR_ARB    1   1 = round-robin on ALU/LSU conflict; 0 = fixed priority, LSU wins
// PORTS
// - clk           in   1           single clock, all state on posedge
// - rst           in   1           asynchronous, active-high reset
// - iss_valid     in   1           decode issues an instr that will write iss_rd
// - iss_rd        in   REG_ADDR_W  destination of the issuing instr
// - iss_ready     out  1           issue accepted (0 = WAW stall)
// - q_rs1/q_rs2   in   REG_ADDR_W  decode source-register queries
// - rs1_busy      out  1           q_rs1 has a pending write (RAW stall)
// - rs2_busy      out  1           q_rs2 has a pending write (RAW stall)
// - alu_valid     in   1           ALU result valid
// - alu_ready     out  1           ALU result accepted this cycle
// - alu_rd        in   REG_ADDR_W  ALU result destination
// - alu_data      in   DATA_W      ALU result data
// - lsu_valid     in   1           load result valid
// - lsu_ready     out  1           load result accepted this cycle
// - lsu_rd        in   REG_ADDR_W  load result destination
// - lsu_data      in   DATA_W      load result data
// - rf_we         out  1           regfile write enable
// - rf_rd_addr    out  REG_ADDR_W  regfile write address
// - rf_rd_data    out  DATA_W      regfile write data
// - busy_vec      out  REG_COUNT   scoreboard bits, for debug and bench use
// - wb_err        out  1           sticky: writeback to a register with no pending write
// - wb_count      out  32          count of regfile writes performed
// BEHAVIOUR
// - Reset: busy_vec=0, rf_we=0, rf_rd_addr=0, rf_rd_data=0, wb_err=0, wb_count=0, last_grant=ALU.
//   Reset is async and takes effect mid-operation; in-flight results are dropped.
// - Issue handshake
//   - iss_ready = !busy[iss_rd] || iss_rd==0, computed from the registered bit.
//   - On iss_valid&&iss_ready with iss_rd!=0, busy[iss_rd] sets at the edge.
//   - An issue to r0 never sets busy.
// - Hazard outputs: rsX_busy = busy[q_rsX] (combinational); always 0 when q_rsX==0.
// - Source handshake: a source's ready is high in the cycle it is granted. Acceptance = valid&&ready.
// - Arbitration on each cycle
//   - Only one valid source: grant it.
//   - Both valid, RR_ARB=1: grant the source that is not last_grant; last_grant updates on every grant.
//   - Both valid, RR_ARB=0: grant LSU.
//   - The loser holds valid/rd/data stable until it is accepted.
// - Write stage, registered, 1-cycle latency
//   - Accept in cycle N drives rf_we=1 with that rd/data in cycle N+1.
//   - The regfile latches the write at the end of N+1; the value is readable in N+2.
//   - No accept in N gives rf_we=0 in N+1; addr/data hold their last value.
//   - Accepted rd==0: handshake completes, rf_we stays 0, no count.
// - Scoreboard clear: busy[rf_rd_addr] clears at the end of the cycle where rf_we=1. Clears and sets never hit the same register in one cycle, because iss_ready uses the pre-clear bit.
// - wb_err sets when an accepted rd!=0 has busy[rd]==0; the write is still performed. Cleared only by rst.
// - wb_count increments by 1 per rf_we=1 cycle and wraps at 2^32.
// STRUCTURE
// - REG_ADDR_W and REG_COUNT come from isa_defs_pkg.
// - Add to isa_defs_pkg: typedef enum logic {WB_SRC_ALU, WB_SRC_LSU} wb_src_e.
// - One sub-module: wb_arb2, the 2-way round-robin/fixed arbiter producing grants and last_grant.
// - Scoreboard, write stage and counter live in the top module.
// TESTING
// - Issue rd=3; ALU alu_rd=3, data 0xDEAD_BEEF -> rs1_busy(q=3)=1 until end of rf_we cycle; rf_we=1 one cycle after accept; wb_count=1.
// - Issue rd=5, then issue rd=5 again -> iss_ready=0 on the second issue until rd=5 is written back, then 1.
// - Both sources valid for 4 cycles (rd=1..4 issued), RR_ARB=1 -> grant order LSU,ALU,LSU,ALU; the loser's data is held and written intact.
// - RR_ARB=0, both valid -> LSU granted every cycle; ALU is granted only when lsu_valid=0.
// - ALU writes rd=0 -> alu_ready=1, rf_we stays 0, wb_count unchanged; an ALU write to non-busy rd=6 -> wb_err=1, sticky.
// - Assert rst while rf_we=1 and busy_vec=0x0E -> all outputs return to reset values immediately; the next issue is accepted.

Source files
------------

// File: rtl/isa_defs_pkg.sv
// Shared ISA-level constants and writeback types for the integer register file.
package isa_defs_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_COUNT  = 1 << REG_ADDR_W;

  typedef enum logic {WB_SRC_ALU, WB_SRC_LSU} wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Issue, hazard-query, ALU/LSU result and regfile write-port signals of the writeback controller.
interface regfile_wb_ctrl_if
  import isa_defs_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic                  iss_ready;
  logic [REG_ADDR_W-1:0] q_rs1;
  logic [REG_ADDR_W-1:0] q_rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0]     alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0]     lsu_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0]     rf_rd_data;

  modport master (
    output iss_valid, iss_rd, q_rs1, q_rs2,
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
    input  rf_we, rf_rd_addr, rf_rd_data
  );

  modport slave (
    input  iss_valid, iss_rd, q_rs1, q_rs2,
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
    output rf_we, rf_rd_addr, rf_rd_data
  );

endinterface

// File: rtl/regfile_wb_arb2.sv
// Two-way ALU/LSU arbiter: round-robin or fixed LSU priority, tracks the last granted source.
module regfile_wb_arb2
  import isa_defs_pkg::*;
#(
  parameter bit RR_ARB = 1'b1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_alu_valid,
  input  logic    i_lsu_valid,
  output logic    o_alu_gnt,
  output logic    o_lsu_gnt,
  output wb_src_e o_last_grant
);

  wb_src_e r_last;
  wb_src_e w_last_d;
  logic    w_lsu_pref;

  // On conflict the LSU wins unless round-robin says the LSU went last.
  assign w_lsu_pref = (RR_ARB == 1'b0) || (r_last == WB_SRC_ALU);
  assign o_lsu_gnt  = i_lsu_valid && (!i_alu_valid || w_lsu_pref);
  assign o_alu_gnt  = i_alu_valid && !o_lsu_gnt;

  always_comb begin
    w_last_d = r_last;
    if (o_lsu_gnt) begin
      w_last_d = WB_SRC_LSU;
    end else if (o_alu_gnt) begin
      w_last_d = WB_SRC_ALU;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= WB_SRC_ALU;
    end else begin
      r_last <= w_last_d;
    end
  end

  assign o_last_grant = r_last;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-side controller: pending-write scoreboard, ALU/LSU merge, registered write stage.
module regfile_wb_ctrl
  import isa_defs_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter bit          RR_ARB = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  regfile_wb_ctrl_if.slave     bus,
  output logic [REG_COUNT-1:0] o_busy_vec,
  output logic                 o_wb_err,
  output logic [31:0]          o_wb_count
);

  logic [REG_COUNT-1:0]  r_busy;
  logic [REG_COUNT-1:0]  w_busy_d;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_err;
  logic [31:0]           r_count;

  logic                  w_alu_gnt;
  logic                  w_lsu_gnt;
  wb_src_e               w_last_grant;
  logic                  w_accept;
  logic [REG_ADDR_W-1:0] w_acc_rd;
  logic [DATA_W-1:0]     w_acc_data;
  logic                  w_acc_write;
  logic                  w_iss_fire;

  regfile_wb_arb2 #(
    .RR_ARB (RR_ARB)
  ) u_arb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_alu_valid  (bus.alu_valid),
    .i_lsu_valid  (bus.lsu_valid),
    .o_alu_gnt    (w_alu_gnt),
    .o_lsu_gnt    (w_lsu_gnt),
    .o_last_grant (w_last_grant)
  );

  assign bus.alu_ready = w_alu_gnt;
  assign bus.lsu_ready = w_lsu_gnt;

  assign w_accept    = w_alu_gnt || w_lsu_gnt;
  assign w_acc_rd    = w_lsu_gnt ? bus.lsu_rd : bus.alu_rd;
  assign w_acc_data  = w_lsu_gnt ? bus.lsu_data : bus.alu_data;
  assign w_acc_write = w_accept && (w_acc_rd != '0);

  assign bus.iss_ready = !r_busy[bus.iss_rd] || (bus.iss_rd == '0);
  assign w_iss_fire    = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);
  assign bus.rs1_busy  = r_busy[bus.q_rs1] && (bus.q_rs1 != '0);
  assign bus.rs2_busy  = r_busy[bus.q_rs2] && (bus.q_rs2 != '0);

  // Issue checks the pre-clear bit, so a set never lands on the register being cleared.
  always_comb begin
    w_busy_d = r_busy;
    if (r_we) begin
      w_busy_d[r_addr] = 1'b0;
    end
    if (w_iss_fire) begin
      w_busy_d[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_busy <= w_busy_d;
      r_we   <= w_acc_write;
      if (w_acc_write) begin
        r_addr <= w_acc_rd;
        r_data <= w_acc_data;
        if (!r_busy[w_acc_rd]) begin
          r_err <= 1'b1;
        end
      end
      if (r_we) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign bus.rf_we      = r_we;
  assign bus.rf_rd_addr = r_addr;
  assign bus.rf_rd_data = r_data;
  assign o_busy_vec     = r_busy;
  assign o_wb_err       = r_err;
  assign o_wb_count     = r_count;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: round-robin instance plus a fixed-priority instance.
module tb_regfile_wb_ctrl;
  import isa_defs_pkg::*;

  logic clk;
  logic rst;

  regfile_wb_ctrl_if #(.DATA_W(32)) ifc_rr ();
  regfile_wb_ctrl_if #(.DATA_W(32)) ifc_fp ();

  logic [REG_COUNT-1:0] busy_rr, busy_fp;
  logic                 err_rr, err_fp;
  logic [31:0]          cnt_rr, cnt_fp;

  regfile_wb_ctrl #(.DATA_W(32), .RR_ARB(1'b1)) u_dut_rr (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (ifc_rr),
    .o_busy_vec (busy_rr),
    .o_wb_err   (err_rr),
    .o_wb_count (cnt_rr)
  );

  regfile_wb_ctrl #(.DATA_W(32), .RR_ARB(1'b0)) u_dut_fp (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (ifc_fp),
    .o_busy_vec (busy_fp),
    .o_wb_err   (err_fp),
    .o_wb_count (cnt_fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc_rr.iss_valid = 0; ifc_rr.iss_rd = 0; ifc_rr.q_rs1 = 0; ifc_rr.q_rs2 = 0;
    ifc_rr.alu_valid = 0; ifc_rr.alu_rd = 0; ifc_rr.alu_data = 0;
    ifc_rr.lsu_valid = 0; ifc_rr.lsu_rd = 0; ifc_rr.lsu_data = 0;
    ifc_fp.iss_valid = 0; ifc_fp.iss_rd = 0; ifc_fp.q_rs1 = 0; ifc_fp.q_rs2 = 0;
    ifc_fp.alu_valid = 0; ifc_fp.alu_rd = 0; ifc_fp.alu_data = 0;
    ifc_fp.lsu_valid = 0; ifc_fp.lsu_rd = 0; ifc_fp.lsu_data = 0;
  endtask

  task automatic issue_rr(input logic [REG_ADDR_W-1:0] rd);
    ifc_rr.iss_valid = 1;
    ifc_rr.iss_rd    = rd;
    cyc();
    ifc_rr.iss_valid = 0;
  endtask

  // Round-robin conflict vectors: per cycle, expected grant and the write that follows.
  logic [3:0]            rr_lsu_gnt = 4'b0101;
  logic [REG_ADDR_W-1:0] alu_rd_v [2] = '{3'd1, 3'd3};
  logic [31:0]           alu_dat_v[2] = '{32'hA1A1_0001, 32'hA3A3_0003};
  logic [REG_ADDR_W-1:0] lsu_rd_v [2] = '{3'd2, 3'd4};
  logic [31:0]           lsu_dat_v[2] = '{32'h1212_0002, 32'h1414_0004};
  logic [REG_ADDR_W-1:0] exp_addr [4] = '{3'd2, 3'd1, 3'd4, 3'd3};
  logic [31:0]           exp_data [4] = '{32'h1212_0002, 32'hA1A1_0001,
                                          32'h1414_0004, 32'hA3A3_0003};

  initial begin
    int ai;
    int li;
    clear_inputs();
    rst = 1'b1;
    #2;
    check_eq("rst_busy_vec", 32'(busy_rr), 32'h0);
    check_eq("rst_rf_we", 32'(ifc_rr.rf_we), 32'h0);
    check_eq("rst_rf_addr", 32'(ifc_rr.rf_rd_addr), 32'h0);
    check_eq("rst_rf_data", ifc_rr.rf_rd_data, 32'h0);
    check_eq("rst_wb_err", 32'(err_rr), 32'h0);
    check_eq("rst_wb_count", cnt_rr, 32'h0);
    #1 rst = 1'b0;
    cyc();

    // Issue rd=3, ALU writes it back.
    ifc_rr.q_rs1 = 3;
    issue_rr(3);
    check_eq("t1_busy_vec", 32'(busy_rr), 32'h08);
    check_eq("t1_rs1_busy_after_issue", 32'(ifc_rr.rs1_busy), 32'h1);
    ifc_rr.alu_valid = 1; ifc_rr.alu_rd = 3; ifc_rr.alu_data = 32'hDEAD_BEEF;
    #1;
    check_eq("t1_alu_ready", 32'(ifc_rr.alu_ready), 32'h1);
    cyc();
    ifc_rr.alu_valid = 0;
    check_eq("t1_rf_we", 32'(ifc_rr.rf_we), 32'h1);
    check_eq("t1_rf_addr", 32'(ifc_rr.rf_rd_addr), 32'h3);
    check_eq("t1_rf_data", ifc_rr.rf_rd_data, 32'hDEAD_BEEF);
    check_eq("t1_rs1_busy_in_we_cycle", 32'(ifc_rr.rs1_busy), 32'h1);
    cyc();
    check_eq("t1_rf_we_drop", 32'(ifc_rr.rf_we), 32'h0);
    check_eq("t1_rs1_busy_cleared", 32'(ifc_rr.rs1_busy), 32'h0);
    check_eq("t1_wb_count", cnt_rr, 32'd1);
    check_eq("t1_wb_err", 32'(err_rr), 32'h0);

    // WAW stall on rd=5.
    issue_rr(5);
    ifc_rr.iss_valid = 1; ifc_rr.iss_rd = 5;
    ifc_rr.alu_valid = 1; ifc_rr.alu_rd = 5; ifc_rr.alu_data = 32'h0000_0055;
    #1;
    check_eq("t2_iss_ready_stall", 32'(ifc_rr.iss_ready), 32'h0);
    cyc();
    ifc_rr.alu_valid = 0;
    check_eq("t2_iss_ready_in_we_cycle", 32'(ifc_rr.iss_ready), 32'h0);
    cyc();
    check_eq("t2_iss_ready_released", 32'(ifc_rr.iss_ready), 32'h1);
    cyc();
    ifc_rr.iss_valid = 0;
    check_eq("t2_busy_reissued", 32'(busy_rr), 32'h20);
    ifc_rr.alu_valid = 1; ifc_rr.alu_rd = 5; ifc_rr.alu_data = 32'h1;
    cyc();
    ifc_rr.alu_valid = 0;
    cyc();
    check_eq("t2_busy_idle", 32'(busy_rr), 32'h0);
    check_eq("t2_wb_count", cnt_rr, 32'd3);

    // Round-robin conflict, rd=1..4 pending.
    for (int r = 1; r <= 4; r++) issue_rr(REG_ADDR_W'(r));
    check_eq("t3_busy_vec", 32'(busy_rr), 32'h1E);
    ai = 0;
    li = 0;
    for (int c = 0; c < 4; c++) begin
      ifc_rr.alu_valid = (ai < 2);
      ifc_rr.lsu_valid = (li < 2);
      if (ai < 2) begin ifc_rr.alu_rd = alu_rd_v[ai]; ifc_rr.alu_data = alu_dat_v[ai]; end
      if (li < 2) begin ifc_rr.lsu_rd = lsu_rd_v[li]; ifc_rr.lsu_data = lsu_dat_v[li]; end
      #1;
      check_eq($sformatf("t3_lsu_ready_c%0d", c), 32'(ifc_rr.lsu_ready), 32'(rr_lsu_gnt[c]));
      check_eq($sformatf("t3_alu_ready_c%0d", c), 32'(ifc_rr.alu_ready), 32'(!rr_lsu_gnt[c]));
      cyc();
      if (rr_lsu_gnt[c]) li++; else ai++;
      check_eq($sformatf("t3_rf_we_c%0d", c), 32'(ifc_rr.rf_we), 32'h1);
      check_eq($sformatf("t3_rf_addr_c%0d", c), 32'(ifc_rr.rf_rd_addr), 32'(exp_addr[c]));
      check_eq($sformatf("t3_rf_data_c%0d", c), ifc_rr.rf_rd_data, exp_data[c]);
    end
    ifc_rr.alu_valid = 0;
    ifc_rr.lsu_valid = 0;
    cyc();
    check_eq("t3_busy_idle", 32'(busy_rr), 32'h0);
    check_eq("t3_wb_count", cnt_rr, 32'd7);
    check_eq("t3_wb_err", 32'(err_rr), 32'h0);

    // Fixed priority: ALU waits while LSU stays valid.
    ifc_fp.alu_valid = 1; ifc_fp.alu_rd = 1; ifc_fp.alu_data = 32'hAAAA_0001;
    ifc_fp.lsu_valid = 1;
    for (int c = 0; c < 3; c++) begin
      ifc_fp.lsu_rd = REG_ADDR_W'(c + 2);
      ifc_fp.lsu_data = 32'h5500_0000 + 32'(c);
      #1;
      check_eq($sformatf("t4_lsu_ready_c%0d", c), 32'(ifc_fp.lsu_ready), 32'h1);
      check_eq($sformatf("t4_alu_ready_c%0d", c), 32'(ifc_fp.alu_ready), 32'h0);
      cyc();
    end
    ifc_fp.lsu_valid = 0;
    #1;
    check_eq("t4_alu_ready_alone", 32'(ifc_fp.alu_ready), 32'h1);
    cyc();
    ifc_fp.alu_valid = 0;
    check_eq("t4_rf_data_alu", ifc_fp.rf_rd_data, 32'hAAAA_0001);

    // Writes to r0 and to a register with nothing pending.
    ifc_rr.alu_valid = 1; ifc_rr.alu_rd = 0; ifc_rr.alu_data = 32'h0BAD_0000;
    #1;
    check_eq("t5_r0_alu_ready", 32'(ifc_rr.alu_ready), 32'h1);
    cyc();
    check_eq("t5_r0_rf_we", 32'(ifc_rr.rf_we), 32'h0);
    ifc_rr.alu_rd = 6; ifc_rr.alu_data = 32'h0000_0066;
    cyc();
    ifc_rr.alu_valid = 0;
    check_eq("t5_r0_wb_count", cnt_rr, 32'd7);
    check_eq("t5_r6_rf_we", 32'(ifc_rr.rf_we), 32'h1);
    check_eq("t5_r6_rf_addr", 32'(ifc_rr.rf_rd_addr), 32'h6);
    check_eq("t5_wb_err_set", 32'(err_rr), 32'h1);
    cyc();
    cyc();
    check_eq("t5_wb_count", cnt_rr, 32'd8);
    check_eq("t5_wb_err_sticky", 32'(err_rr), 32'h1);

    // Asynchronous reset while a write is in flight.
    for (int r = 1; r <= 3; r++) issue_rr(REG_ADDR_W'(r));
    ifc_rr.alu_valid = 1; ifc_rr.alu_rd = 1; ifc_rr.alu_data = 32'h1111_1111;
    cyc();
    ifc_rr.alu_valid = 0;
    check_eq("t6_pre_rf_we", 32'(ifc_rr.rf_we), 32'h1);
    check_eq("t6_pre_busy_vec", 32'(busy_rr), 32'h0E);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_rf_we", 32'(ifc_rr.rf_we), 32'h0);
    check_eq("t6_rst_busy_vec", 32'(busy_rr), 32'h0);
    check_eq("t6_rst_rf_addr", 32'(ifc_rr.rf_rd_addr), 32'h0);
    check_eq("t6_rst_rf_data", ifc_rr.rf_rd_data, 32'h0);
    check_eq("t6_rst_wb_err", 32'(err_rr), 32'h0);
    check_eq("t6_rst_wb_count", cnt_rr, 32'h0);
    rst = 1'b0;
    ifc_rr.iss_valid = 1; ifc_rr.iss_rd = 7;
    #1;
    check_eq("t6_iss_ready", 32'(ifc_rr.iss_ready), 32'h1);
    cyc();
    ifc_rr.iss_valid = 0;
    check_eq("t6_busy_after_issue", 32'(busy_rr), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
